// File: rtl/fsm_sched_pkg.sv
// Shared types for the fsm_sched request scheduler: controller state encoding
// and the state codes reported by the downstream fsm on zot.
package fsm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] ZOT_IDLE = 3'b000;
    localparam logic [2:0] ZOT_S1   = 3'b101;
    localparam logic [2:0] ZOT_S2   = 3'b111;
    localparam logic [2:0] ZOT_S3   = 3'b001;

endpackage

// File: rtl/fsm_sched_rr.sv
// Round-robin pick: returns a one-hot grant for the first requester found
// after ptr (the last grantee), wrapping from N_REQ-1 back to 0.
module fsm_sched_rr
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // Offset N_REQ lands back on ptr itself, so the last grantee goes last.
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_sched.sv
// Shares one fsm sequencer among N_REQ requesters. Optional watchdog on the
// RUN phase is enabled by defining FSM_SCHED_TIMEOUT_EN.
//
// Handshake: a requester holds req high until its one-cycle done pulse; the
// grant is taken only in IDLE with zot idle, and nothing aborts a granted
// operation except reset (or the watchdog, when built in).
module fsm_sched
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WAIT_W  = 4,
    parameter int TMO_CYC = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        skip_req,
    input  logic [N_REQ*WAIT_W-1:0] wait_len,
    input  logic [2:0]              zot,
    output logic                    start,
    output logic                    skip3,
    output logic                    wait3,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    err,
    output logic [1:0]              dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (TMO_CYC < 2) begin : g_bad_tmo
        $error("fsm_sched: TMO_CYC must be at least 2");
    end

    state_t              state, nstate;
    logic [N_REQ-1:0]    rr_gnt, gnt_q, done_q;
    logic [PW-1:0]       ptr_q, win_idx;
    logic                skip_q, seen_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                grant_fire, tmo_hit;

    fsm_sched_rr #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) win_idx = PW'(i);
        end
    end

    always_comb begin
        nstate     = state;
        grant_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req && zot == ZOT_IDLE) begin
                    grant_fire = 1'b1;
                    nstate     = ST_START;
                end
            end
            ST_START: nstate = ST_RUN;
            ST_RUN: begin
                // seen_q guards against the idle zot before the fsm reacts to start.
                if (seen_q && zot == ZOT_IDLE) nstate = ST_DONE;
                else if (tmo_hit)              nstate = ST_IDLE;
            end
            ST_DONE: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            gnt_q  <= '0;
            done_q <= '0;
            ptr_q  <= PW'(N_REQ - 1);
            skip_q <= 1'b0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= nstate;
            done_q <= '0;
            if (grant_fire) begin
                gnt_q  <= rr_gnt;
                ptr_q  <= win_idx;
                skip_q <= |(skip_req & rr_gnt);
                cnt_q  <= wait_len[win_idx*WAIT_W +: WAIT_W];
                seen_q <= 1'b0;
            end else if (state == ST_RUN) begin
                if (zot != ZOT_IDLE)                  seen_q <= 1'b1;
                if (zot == ZOT_S3 && cnt_q != '0)     cnt_q  <= cnt_q - 1'b1;
                if (nstate != ST_RUN)                 gnt_q  <= '0;
                if (nstate == ST_DONE)                done_q <= gnt_q;
            end
        end
    end

`ifdef FSM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit = (state == ST_RUN) && (tmo_q == TW'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_RUN) && (nstate == ST_IDLE);
            if (state == ST_RUN) tmo_q <= tmo_q + 1'b1;
            else                 tmo_q <= '0;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign start     = (state == ST_START);
    assign skip3     = (state == ST_RUN) && skip_q;
    assign wait3     = (state == ST_RUN) && (zot == ZOT_S3) && (cnt_q != '0);
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = |gnt_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_fsm_sched.sv
// Bench for fsm_sched: emulates the downstream fsm and predicts every output
// from a timeline model of each granted operation.
`timescale 1ns/1ps
module tb_fsm_sched;
    import fsm_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 4;
`ifdef FSM_SCHED_TIMEOUT_EN
    localparam int TMO  = 8;
    localparam int MAXW = 3;
`else
    localparam int TMO  = 64;
    localparam int MAXW = 15;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req, skip_req, gnt, done;
    logic [N*W-1:0] wait_len;
    logic [2:0]     zot;
    logic           start, skip3, wait3, busy, err, stuck;
    logic [1:0]     dbg_state;

    fsm_sched #(.N_REQ(N), .WAIT_W(W), .TMO_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .skip_req(skip_req),
        .wait_len(wait_len), .zot(zot), .start(start), .skip3(skip3),
        .wait3(wait3), .gnt(gnt), .done(done), .busy(busy), .err(err),
        .dbg_state(dbg_state)
    );

    // Downstream fsm: idle -> s1 on start, s1 -> s2, s2 -> idle/s3 by skip3,
    // s3 holds while wait3. stuck parks it in s2 once it has left idle.
    always @(posedge clk or posedge reset) begin
        if (reset) zot <= ZOT_IDLE;
        else if (stuck && zot != ZOT_IDLE) zot <= ZOT_S2;
        else begin
            case (zot)
                ZOT_IDLE: if (start) zot <= ZOT_S1;
                ZOT_S1:   zot <= ZOT_S2;
                ZOT_S2:   zot <= skip3 ? ZOT_IDLE : ZOT_S3;
                ZOT_S3:   zot <= wait3 ? ZOT_S3 : ZOT_IDLE;
                default:  zot <= ZOT_IDLE;
            endcase
        end
    end

    // ---------------- scoreboard / model state ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [N-1:0] exp_q[$];
    bit m_act, m_skip;
    int m_t0, m_len, m_owner, m_w, m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_last = N - 1;
        exp_q.delete();
    endtask

    // An operation granted in cycle t0 has start at t0+1, s3 from t0+4 and
    // done at t0+5 (skip) or t0+6+W; the controller is free again at len+1.
    task automatic model_decide();
        logic [N-1:0] oh;
        int idx;
        if (!reset && (!m_act || cyc > m_t0 + m_len) && req != '0) begin
            m_owner = -1;
            for (int off = 1; off <= N; off++) begin
                idx = (m_last + off) % N;
                if (m_owner < 0 && req[idx]) m_owner = idx;
            end
            m_act  = 1'b1;
            m_t0   = cyc;
            m_last = m_owner;
            m_skip = skip_req[m_owner];
            m_w    = int'(wait_len[m_owner*W +: W]);
            m_len  = m_skip ? 5 : 6 + m_w;
            oh = '0;
            oh[m_owner] = 1'b1;
            exp_q.push_back(oh);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step();
        logic [N-1:0] e_gnt, e_done;
        int k;
        model_decide();
        tick();
        k = cyc - m_t0;
        e_gnt  = '0;
        e_done = '0;
        if (m_act && k >= 1 && k < m_len) e_gnt[m_owner]  = 1'b1;
        if (m_act && k == m_len)          e_done[m_owner] = 1'b1;
        check_eq("gnt",   gnt,   e_gnt);
        check_eq("busy",  busy,  |e_gnt);
        check_eq("done",  done,  e_done);
        check_eq("start", start, m_act && k == 1);
        check_eq("skip3", skip3, m_act && m_skip && k >= 2 && k < m_len);
        check_eq("wait3", wait3, m_act && !m_skip && k >= 4 && k < 4 + m_w);
        check_eq("err",   err,   1'b0);
        if (done != '0) begin
            if (exp_q.size() == 0) check_eq("done_unexpected", done, 0);
            else                   check_eq("done_owner", done, exp_q.pop_front());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_async_outs", {start, skip3, wait3, busy, err, gnt, done}, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            req = req & ~done;
        end
    endtask

    task automatic directed_op(input logic [N-1:0] r, input logic [N-1:0] s,
                               input logic [N*W-1:0] wl, output int start_c,
                               output int done_c, output int w3, output int s3,
                               output logic [N-1:0] done_v);
        req = r; skip_req = s; wait_len = wl;
        start_c = -1; done_c = -1; w3 = 0; s3 = 0; done_v = '0;
        for (int i = 0; i < 40 && done_c < 0; i++) begin
            step();
            if (start)         start_c = cyc;
            if (wait3)         w3++;
            if (zot == ZOT_S3) s3++;
            if (done != '0) begin
                done_c = cyc;
                done_v = done;
                req    = req & ~done;
            end
        end
        check_eq("op_completed", done_c >= 0, 1'b1);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc, dc, w3, s3, n;
        int got[5];
        logic [N-1:0] dv;

        req = '0; skip_req = '0; wait_len = '0; stuck = 1'b0;
        model_reset();
        #1;
        apply_reset();

        // Skipped s3: done four cycles after start, wait3 silent.
        directed_op(4'b0001, 4'b0001, '0, sc, dc, w3, s3, dv);
        check_eq("skip_latency", dc - sc, 4);
        check_eq("skip_wait3",   w3, 0);
        check_eq("skip_owner",   dv, 4'b0001);

        // wait_len=3 on requester 1: three wait3 cycles, four s3 cycles.
        directed_op(4'b0010, 4'b0000, 16'h0030, sc, dc, w3, s3, dv);
        check_eq("wait_latency", dc - sc, 8);
        check_eq("wait_wait3",   w3, 3);
        check_eq("wait_s3",      s3, 4);
        check_eq("wait_owner",   dv, 4'b0010);

        // wait_len=0 without skip: a single s3 cycle.
        directed_op(4'b0100, 4'b0000, '0, sc, dc, w3, s3, dv);
        check_eq("w0_latency", dc - sc, 5);
        check_eq("w0_wait3",   w3, 0);
        check_eq("w0_s3",      s3, 1);

        // All requesting: grants rotate 0,1,2,3 then wrap to 0.
        apply_reset();
        for (int i = 0; i < 5; i++) got[i] = -1;
        req = '1; skip_req = '1; n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            step();
            if (start) begin
                got[n] = onehot_idx(gnt);
                n++;
            end
        end
        req = '0;
        check_eq("rr_count", n, 5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("rr_order%0d", i), got[i], i % N);
        drain(10);

        // Reset while the fsm dwells in s3: operation abandoned, pointer back to 0.
        req = 4'b0100; skip_req = '0; wait_len = 16'h0500;
        for (int i = 0; i < 20 && zot != ZOT_S3; i++) step();
        check_eq("rst_reach_s3", zot, ZOT_S3);
        apply_reset();
        req = 4'b0101; skip_req = 4'b0001; wait_len = '0;
        n = -1;
        for (int i = 0; i < 10 && n < 0; i++) begin
            step();
            if (start) n = onehot_idx(gnt);
        end
        check_eq("rst_next_owner", n, 0);
        drain(25);

        // Owner drops req in RUN while requester 2 rises.
        req = 4'b0001; skip_req = 4'b0100; wait_len = 16'h0002;
        n = -1;
        for (int i = 0; i < 10 && n < 0; i++) begin
            step();
            if (start) n = onehot_idx(gnt);
        end
        check_eq("drop_owner", n, 0);
        step();
        step();
        req = 4'b0100;
        dv = '0;
        for (int i = 0; i < 20 && dv == '0; i++) begin
            step();
            dv = done;
        end
        check_eq("drop_done", dv, 4'b0001);
        n = -1;
        for (int i = 0; i < 10 && n < 0; i++) begin
            step();
            if (start) n = onehot_idx(gnt);
        end
        check_eq("drop_next_owner", n, 2);
        drain(12);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]          = 1'b1;
                    skip_req[i]     = 1'($urandom_range(0, 1));
                    wait_len[i*W +: W] = W'($urandom_range(0, MAXW));
                end
            end
            step();
            req = req & ~done;
        end
        req = '0;
        drain(30);
        check_eq("rand_drained", exp_q.size(), 0);

`ifdef FSM_SCHED_TIMEOUT_EN
        // fsm parked in s2: watchdog fires after 8 RUN cycles, no done.
        stuck = 1'b1; req = 4'b0001; skip_req = '0; wait_len = '0;
        tick();
        check_eq("tmo_start", start, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("tmo_run_busy", busy, 1'b1);
            check_eq("tmo_run_err",  err,  1'b0);
        end
        tick();
        check_eq("tmo_err",  err,  1'b1);
        check_eq("tmo_busy", busy, 1'b0);
        check_eq("tmo_done", done, '0);
        tick();
        check_eq("tmo_err_pulse", err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("tmo_hold_off", gnt, '0);
        end
        stuck = 1'b0; req = '0;
        apply_reset();
        drain(3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/fsm_sched.md
FSM_SCHED -- requirements
Module: fsm_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the fsm sequencer.
REQ-002 Parameter WAIT_W, default 4: width of each requester's wait-length field.
REQ-003 Parameter TMO_CYC, default 64: watchdog limit in cycles; used only when FSM_SCHED_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester operation request, held high until that requester's done pulse.
REQ-007 skip_req  input  N_REQ  per-requester skip-state-3 selection, sampled at grant.
REQ-008 wait_len  input  N_REQ*WAIT_W  per-requester state-3 dwell count, sampled at grant; slice i is bits [i*WAIT_W +: WAIT_W].
REQ-009 zot  input  3  fsm state output: 000 idle, 101 s1, 111 s2, 001 s3.
REQ-010 start  output  1  one-cycle start pulse to the fsm.
REQ-011 skip3  output  1  skip3 drive to the fsm.
REQ-012 wait3  output  1  wait3 drive to the fsm.
REQ-013 gnt  output  N_REQ  one-hot owner of the current operation.
REQ-014 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-015 busy  output  1  high from the grant cycle until the done cycle.
REQ-016 err  output  1  one-cycle watchdog pulse; tied 0 without FSM_SCHED_TIMEOUT_EN.

Function
REQ-017 The controller SHALL implement states IDLE, START, RUN and DONE.
REQ-018 IDLE: when any req bit is high and zot==000, the controller SHALL select a winner round-robin, starting at the requester after the last grantee; it SHALL then register gnt, latch skip and wait_len, set busy, and go to START.
REQ-019 START: start SHALL be high for exactly this one cycle; next state is RUN.
REQ-020 RUN: skip3 SHALL equal the latched skip bit.
REQ-021 RUN: wait3 SHALL be high (combinational) while zot==001 and the wait counter is nonzero; the counter SHALL decrement each cycle zot==001, so the fsm stays in s3 for wait_len+1 cycles.
REQ-022 RUN SHALL exit to DONE on the first cycle zot==000 after zot has been non-zero at least once.
REQ-023 DONE: done[owner] SHALL pulse for one cycle; gnt and busy SHALL clear; next state is IDLE.
REQ-024 Latency from grant to done SHALL be 5 cycles with skip=1, and 6+W cycles with skip=0 and wait_len=W.
REQ-025 Requests arriving during busy SHALL be held off; a req deassert by the owner mid-operation SHALL NOT abort the operation.
REQ-026 With wait_len=0 and skip=0, wait3 SHALL never assert, giving one s3 cycle.
REQ-027 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-028 In IDLE, start, skip3 and wait3 SHALL be 0.

Reset
REQ-029 On reset assertion, the controller SHALL immediately enter IDLE and drive start, skip3, wait3, gnt, done, busy and err to 0, the counter to 0, and the pointer so that requester 0 wins first.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-031 With FSM_SCHED_TIMEOUT_EN defined: if RUN lasts TMO_CYC cycles, err SHALL pulse and the controller SHALL return to IDLE with no done pulse; the next grant SHALL still wait for zot==000.
REQ-032 Without FSM_SCHED_TIMEOUT_EN: there SHALL be no watchdog counter, err SHALL be constant 0, and RUN SHALL be unbounded.

Structure
REQ-033 Package fsm_sched_pkg SHALL hold the controller state encoding and the ZOT_IDLE/S1/S2/S3 codes (000/101/111/001).
REQ-034 The round-robin selection SHALL be sub-module fsm_sched_rr, taking req and the pointer and returning a one-hot grant.

Verification
REQ-035 The bench SHALL cover: req=0001, skip_req=1 -> start at T+1, done[0] at T+5, wait3 never high.
REQ-036 The bench SHALL cover: req=0010, skip_req=0, wait_len=3 -> wait3 high 3 cycles, zot==001 for 4 cycles, done[1] at T+9.
REQ-037 The bench SHALL cover: req=1111 held for 4 operations -> grant order 0,1,2,3, then 0 again.
REQ-038 The bench SHALL cover: reset pulsed while zot==001 -> all outputs 0 next edge, no done pulse, next grant goes to requester 0.
REQ-039 The bench SHALL cover, with FSM_SCHED_TIMEOUT_EN and TMO_CYC=8: zot stuck at 111 -> err pulses after 8 RUN cycles, no done pulse.
REQ-040 The bench SHALL cover: owner drops req in RUN while req[2] rises -> the operation completes with done[owner], then requester 2 is granted.
